// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator: FSM encoding, semitone constants,
// the equal-tempered base frequency table (C4..B4, mHz) and the half-period helper.
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } tone_state_e;

  localparam int unsigned NUM_SEMI  = 12;
  localparam logic [3:0]  SEMI_C    = 4'd0;
  localparam logic [3:0]  SEMI_A    = 4'd9;
  localparam logic [3:0]  SEMI_B    = 4'd11;
  localparam logic [3:0]  SEMI_REST = 4'd12;

  localparam int unsigned BASE_FREQ_MHZ [NUM_SEMI] = '{
    261626, 277183, 293665, 311127, 329628, 349228,
    369994, 391995, 415305, 440000, 466164, 493883
  };

  // Rounded clock cycles per half period of the octave-4 base tone; 0 for rests.
  function automatic longint unsigned tone_half_period(longint unsigned clk_frq,
                                                       int unsigned semi);
    longint unsigned f;
    if (semi >= NUM_SEMI) return 64'd0;
    f = 64'(BASE_FREQ_MHZ[semi]);
    return (clk_frq * 64'd1000 + f) / (64'd2 * f);
  endfunction

  function automatic logic is_rest(logic [3:0] semi);
    return (semi >= SEMI_REST);
  endfunction

endpackage

// File: rtl/tone_div.sv
// Loadable half-period counter: counts 0..HP-1 and toggles its square-wave output on wrap.
module tone_div #(
  parameter int unsigned HP_W = 18
) (
  input  logic            i_clk,
  input  logic            i_rstb,
  input  logic            i_load,
  input  logic            i_load_lvl,
  input  logic            i_en,
  input  logic            i_clr,
  input  logic [HP_W-1:0] i_half_period,
  output logic            o_wave
);

  logic [HP_W-1:0] r_cnt;
  logic            r_wave;
  logic [HP_W:0]   w_cnt_inc;
  logic            w_wrap;

  assign w_cnt_inc = {1'b0, r_cnt} + {{HP_W{1'b0}}, 1'b1};
  assign w_wrap    = (w_cnt_inc >= {1'b0, i_half_period});

  // Load wins over clear so a note accepted on the last cycle of the previous one still starts high.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= '0;
      r_wave <= i_load_lvl;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (i_en) begin
      if (w_wrap) begin
        r_cnt  <= '0;
        r_wave <= ~r_wave;
      end else begin
        r_cnt  <= w_cnt_inc[HP_W-1:0];
      end
    end
  end

  assign o_wave = r_wave;

endmodule

// File: rtl/tone_gen.sv
// Note player: IDLE/PLAY/GAP sequencer with fixed note length and square-wave pitch output.
// Optional macro TONE_GEN_RETRIGGER_EN lets a new note restart the one playing.
module tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned C_CLK_FRQ = 100_000_000,
  parameter int unsigned C_NOTE_MS = 500,
  parameter int unsigned C_GAP_CYC = 1000
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       valid,
  input  logic [7:0] note,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       pwm
);

  localparam longint unsigned NOTE_CYC = 64'(C_NOTE_MS) * 64'(C_CLK_FRQ / 1000);
  localparam int unsigned DUR_W = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;
  localparam int unsigned GAP_W = (C_GAP_CYC > 1) ? $clog2(C_GAP_CYC) : 1;
  localparam longint unsigned HP_MAX = tone_half_period(64'(C_CLK_FRQ), 0);
  localparam int unsigned HP_W = $clog2(HP_MAX + 1);
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(C_GAP_CYC - 1);

  tone_state_e     r_state;
  tone_state_e     w_state_nxt;
  logic [DUR_W-1:0] r_dur;
  logic [GAP_W-1:0] r_gap;
  logic [6:0]      r_note;
  logic            r_done;
  logic            w_accept;
  logic            w_ready;
  logic [HP_W-1:0] w_hp_tab [16];
  logic [HP_W-1:0] w_hp;
  logic            w_div_en;
  logic            w_div_clr;
  logic            w_wave;
  logic            w_unused_note;

  assign w_unused_note = note[7];

  // Rest codes 12..15 map to zero, so the table is indexed by the raw semitone field.
  for (genvar k = 0; k < 16; k++) begin : g_hp
    assign w_hp_tab[k] = HP_W'(tone_half_period(64'(C_CLK_FRQ), unsigned'(k)));
  end

  assign w_hp = w_hp_tab[r_note[3:0]] >> r_note[6:4];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
`ifdef TONE_GEN_RETRIGGER_EN
        w_ready  = 1'b1;
        w_accept = valid;
`else
        w_ready  = 1'b0;
`endif
        if (!w_accept && (r_dur == DUR_LAST)) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (r_gap == GAP_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Duration counts from the first PLAY cycle; a retrigger restarts it from zero.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_dur  <= '0;
      r_gap  <= '0;
      r_note <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_GAP) && (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_note <= note[6:0];
        r_dur  <= '0;
      end else if (r_state == ST_PLAY) begin
        r_dur  <= (r_dur == DUR_LAST) ? '0 : r_dur + 1'b1;
      end
      if (r_state == ST_GAP) begin
        r_gap <= (r_gap == GAP_LAST) ? '0 : r_gap + 1'b1;
      end else begin
        r_gap <= '0;
      end
    end
  end

  assign w_div_en  = (r_state == ST_PLAY) && !is_rest(r_note[3:0]);
  assign w_div_clr = (w_state_nxt != ST_PLAY);

  tone_div #(
    .HP_W(HP_W)
  ) u_div (
    .i_clk        (clk),
    .i_rstb       (rstb),
    .i_load       (w_accept),
    .i_load_lvl   (!is_rest(note[3:0])),
    .i_en         (w_div_en),
    .i_clr        (w_div_clr),
    .i_half_period(w_hp),
    .o_wave       (w_wave)
  );

  assign ready = w_ready;
  assign busy  = (r_state != ST_IDLE);
  assign done  = r_done;
  assign pwm   = w_wave;

endmodule
